id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between decode and execute in the 5-stage RV32I core.
- Captures the control-decoder outputs and the decoded operands, and presents them to EX one cycle later.
- Owns load-use hazard detection: it inserts a bubble and back-pressures ID.
- Owns EX-redirect flush: it squashes the instruction entering EX when the branch/jump in EX redirects the PC.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_result_src  in  2  writeback source (00 ALU, 01 memory, 10 PC+4).
- id_mem_write, id_alu_src, id_reg_write, id_jump, id_branch  in  1 each  decoder controls.
- id_alu_control  in  4  ALU operation.
- id_pc, id_rs1_data, id_rs2_data, id_imm_ext  in  XLEN each  operands.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices.
- ex_ready  in  1  EX can accept a new instruction.
- flush  in  1  PC redirect from EX (taken branch or jump).
- ex_valid  out  1  EX-side contents are valid.
- ex_* outputs  out  matching widths  registered copies of every id_* control, operand and index input.
- load_use_stall  out  1  combinational hazard indication to IF/ID.

Behaviour:
- Reset (asynchronous): every ex_* output is 0 and ex_valid is 0.
- Load-use hazard, combinational: asserted when all of the following hold:
  - ex_valid=1, ex_result_src=01 and ex_reg_write=1;
  - ex_rd≠0;
  - id_valid=1;
  - ex_rd equals id_rs1 or id_rs2.
- load_use_stall = hazard & ~flush.
- id_ready = ex_ready & (~hazard | flush).
- Register update on each rising edge, first matching case wins:
  1. flush=1: capture a bubble regardless of ex_ready. The ID instruction is consumed and discarded (it is a younger, wrong-path instruction).
  2. ex_ready=0: hold all contents unchanged (stall).
  3. hazard=1: capture a bubble. ID is held (id_ready=0).
  4. id_valid=1: capture all id_* fields and set ex_valid=1.
  5. Otherwise: capture a bubble.
- Bubble definition:
  - ex_valid=0 and ex_reg_write=ex_mem_write=ex_jump=ex_branch=0.
  - Datapath fields (pc, data, imm, indices) are don't-care but are driven to 0.
  - A bubble never writes architectural state downstream.
- Latency: one cycle from ID acceptance to EX presentation. Throughput is one instruction per cycle when there is no hazard and ex_ready=1.
- A load-use stall lasts exactly one cycle. Next cycle the load has left EX, the bubble is in EX, and the dependent instruction is accepted.
- Bubble cannot chain: a bubble in EX has ex_valid=0, so it never triggers a hazard.
- rd=x0 never causes a hazard, including a load to x0.
- Simultaneous flush and ex_ready=0: flush wins and the stage bubbles. The redirect must not be lost.
- Reset asserted mid-stall: the stage clears immediately. After reset deassertion, id_ready follows ex_ready.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Enabled:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle in which case 3 is taken.
  - perf_flush_cnt increments each cycle in which case 1 is taken and the EX-side slot being overwritten or the incoming ID slot held a valid instruction.
  - Both counters reset to 0 and wrap modulo 2^32.
- Disabled: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - RESULT_SRC_ALU=2'b00, RESULT_SRC_MEM=2'b01, RESULT_SRC_PC4=2'b10;
  - XLEN and REG_AW defaults;
  - a ctrl_t bundle of the eight control fields, so bubble zeroing is one assignment.
- One sub-module: hazard_detect (purely combinational load-use compare), reused later by the forwarding unit.

Test Plan:
- Back-to-back stream, ex_ready=1, no dependencies: ADD at PC 0x00 then SUB at PC 0x04 → ex_pc shows 0x00, then 0x04 on consecutive cycles; id_ready stays 1.
- Load-use: LW x5 in EX, ID holds ADD x6,x5,x1 → load_use_stall=1 and id_ready=0 for one cycle; next cycle ex_valid=0 with ex_reg_write=0; the cycle after, the ADD appears in EX.
- Load to x0: LW x0 in EX, ID reads rs1=x0 → no stall; id_ready=1.
- Flush during hazard: load-use condition present and flush=1 → load_use_stall=0, id_ready=1; next cycle ex_valid=0, ex_jump=0, ex_branch=0.
- ex_ready=0 for 3 cycles holding SW at PC 0x40 → ex_* stable at PC 0x40 and id_ready=0; on release, the next instruction enters.
- Async reset pulsed mid-stream, between clock edges → ex_valid=0 and all ex_* outputs 0 immediately. With ID_EX_PERF_CNT_EN defined, both counters read 0 after reset.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared definitions for the RV32I pipeline. Holds the
//                writeback-source encodings, the datapath width defaults and
//                the bundle of decoder control fields. A bubble clears the
//                whole bundle with a single assignment.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_REG_AW = 5;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // Decoder control bundle, including the slot valid bit.
    // An all-zero value is a bubble: no register write, no store, no
    // jump and no branch.
    typedef struct packed {
        logic       valid;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Purely combinational load-use compare. Flags the case where
//                the instruction in EX is a valid load writing a non-zero
//                register that the valid instruction in ID reads. The
//                forwarding unit reuses this block.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
    import core_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              ex_valid,
    input  logic [1:0]        ex_result_src,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hazard
);

    logic w_ex_is_load;
    logic w_rd_nonzero;
    logic w_rd_match;

    // A load writing x0 never produces a value, so it cannot cause a hazard.
    always_comb begin
        w_ex_is_load = ex_valid && (ex_result_src == RESULT_SRC_MEM) && ex_reg_write;
        w_rd_nonzero = (ex_rd != '0);
        w_rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        hazard       = w_ex_is_load && w_rd_nonzero && id_valid && w_rd_match;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for the 5-stage RV32I core.
//                Captures decoder controls and operands, inserts a bubble on
//                a load-use hazard (holding ID for one cycle) and squashes
//                the incoming instruction when EX redirects the PC.
//                Optional build macro ID_EX_PERF_CNT_EN adds stall and flush
//                event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [1:0]        id_result_src,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic [3:0]        id_alu_control,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm_ext,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,

    input  logic              ex_ready,
    input  logic              flush,

    output logic              ex_valid,
    output logic [1:0]        ex_result_src,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic [3:0]        ex_alu_control,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm_ext,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,

`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif

    output logic              load_use_stall
);

    ctrl_t             r_ctrl;
    ctrl_t             w_id_ctrl;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm_ext;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;

    logic              w_hazard;
    logic              w_load;
    logic              w_take;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid      (r_ctrl.valid),
        .ex_result_src (r_ctrl.result_src),
        .ex_reg_write  (r_ctrl.reg_write),
        .ex_rd         (r_rd),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .hazard        (w_hazard)
    );

    // Handshake and update decisions. A flush overrides both the stall from
    // EX and the hazard so the redirect is never lost.
    always_comb begin
        w_id_ctrl             = CTRL_BUBBLE;
        w_id_ctrl.valid       = 1'b1;
        w_id_ctrl.result_src  = id_result_src;
        w_id_ctrl.mem_write   = id_mem_write;
        w_id_ctrl.alu_src     = id_alu_src;
        w_id_ctrl.reg_write   = id_reg_write;
        w_id_ctrl.jump        = id_jump;
        w_id_ctrl.branch      = id_branch;
        w_id_ctrl.alu_control = id_alu_control;

        load_use_stall = w_hazard && !flush;
        id_ready       = ex_ready && (!w_hazard || flush);
        // w_load: the register updates this cycle (otherwise EX stall hold).
        // w_take: the update captures the ID instruction rather than a bubble.
        w_load         = flush || ex_ready;
        w_take         = !flush && ex_ready && !w_hazard && id_valid;
    end

    // Pipeline register: capture ID, insert a bubble, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm_ext  <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (w_load) begin
            if (w_take) begin
                r_ctrl     <= w_id_ctrl;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm_ext  <= id_imm_ext;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
            end else begin
                r_ctrl     <= CTRL_BUBBLE;
                r_pc       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm_ext  <= '0;
                r_rs1      <= '0;
                r_rs2      <= '0;
                r_rd       <= '0;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;
    logic        w_stall_event;
    logic        w_flush_event;

    // A flush only counts when it actually squashes a real instruction.
    always_comb begin
        w_stall_event = !flush && ex_ready && w_hazard;
        w_flush_event = flush && (r_ctrl.valid || id_valid);
    end

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_stall_event) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (w_flush_event) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

    assign ex_valid       = r_ctrl.valid;
    assign ex_result_src  = r_ctrl.result_src;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_alu_src     = r_ctrl.alu_src;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_jump        = r_ctrl.jump;
    assign ex_branch      = r_ctrl.branch;
    assign ex_alu_control = r_ctrl.alu_control;
    assign ex_pc          = r_pc;
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm_ext     = r_imm_ext;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;

endmodule
`default_nettype wire
